// File: rtl/instr_encoder_if.sv
// Request/word handshake bundle for the instruction encoder.
// The slave modport is the encoder side; master is the source/sink driving it.
interface instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_word, out_addr
    );

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_word, out_addr
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes symbolic MIPS requests into 32-bit words and streams them to an
// instruction-memory write port through a single registered output stage.
module instr_encoder #(
    parameter int          ADDR_W    = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    instr_encoder_if.slave bus,
    output logic [15:0]   count,
    output logic          error,
    output logic          busy
);
    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] next_addr;
    logic [31:0]       enc_word;
    logic              legal;
    logic              accept;
    logic              xfer;

    assign bus.in_ready = (state == RUN) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = bus.out_valid && bus.out_ready;
    assign legal        = (bus.in_op <= 4'd9);
    assign busy         = (state != IDLE);

    always_comb begin
        enc_word = 32'h0;
        case (bus.in_op)
            4'd0: enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100000};
            4'd1: enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100010};
            4'd2: enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100100};
            4'd3: enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100101};
            4'd4: enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b101010};
            4'd5: enc_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd6: enc_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd7: enc_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd8: enc_word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd9: enc_word = {6'b000010, bus.in_target};
            default: enc_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            next_addr     <= BASE;
            bus.out_valid <= 1'b0;
            bus.out_word  <= 32'h0;
            bus.out_addr  <= '0;
            count         <= 16'h0;
            error         <= 1'b0;
        end else begin
            // Output stage: a legal accept reloads it, otherwise a transfer empties it.
            if (accept && legal) begin
                bus.out_valid <= 1'b1;
                bus.out_word  <= enc_word;
                bus.out_addr  <= next_addr;
            end else if (xfer) begin
                bus.out_valid <= 1'b0;
            end

            if (start) begin
                next_addr <= BASE;
                count     <= 16'h0;
                error     <= 1'b0;
                state     <= RUN;
            end else begin
                if (accept && legal)
                    next_addr <= next_addr + ADDR_W'(4);
                if (xfer && count != 16'hFFFF)
                    count <= count + 16'd1;
                if (accept && !legal)
                    error <= 1'b1;

                case (state)
                    IDLE: state <= IDLE;
                    RUN: begin
                        if (accept && !legal)
                            state <= ERR;
                        else if (stop)
                            state <= (bus.out_valid || accept) ? DRAIN : IDLE;
                    end
                    DRAIN: if (!bus.out_valid || xfer) state <= IDLE;
                    ERR:   state <= ERR;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
